reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
Reset controller that drives the reset inputs of downstream register banks, which are built from our sync- and async-reset flop styles. Raw reset is asserted asynchronously and released synchronously through a synchronizer. Stage resets are then released one at a time in fixed order, with programmable hold and gap intervals. A software-requested reset re-runs the full sequence without a global reset.

Parameters:
NUM_STAGES, 4, number of sequenced reset outputs (>=1)
SYNC_DEPTH, 2, flops in reset synchronizer chain (>=2)
HOLD_CYCLES, 16, cycles all stages stay asserted after synchronized reset release (>=1)
GAP_CYCLES, 8, cycles between successive stage releases (>=1)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
sw_reset_req  input  1  sync pulse/level; requests full reset re-sequence
hold  input  1  while high, sequence cannot leave HOLD state
stage_reset  output  NUM_STAGES  active-high reset per stage; bit 0 released first
all_released  output  1  high when every stage_reset bit is 0
busy  output  1  high in any state other than RUN
sw_reset_ack  output  1  1-cycle pulse when a software-initiated sequence completes

Behaviour:
- Interface: reset is asynchronous, active-high; clock is clk.
- Reset values:
  - stage_reset = all ones; all_released = 0; busy = 1; sw_reset_ack = 0.
  - state = HOLD, cnt = 0, idx = 1, sw_flag = 0.
- Synchronizer: SYNC_DEPTH flops, async-set by reset, shift in 0 each edge; output rst_sync.
- The FSM and all outputs use rst_sync as their async reset. Assertion is immediate; release occurs SYNC_DEPTH edges after reset falls.
- Edge numbering: edge 1 is the first rising clk edge after reset falls. rst_sync goes low after edge SYNC_DEPTH. The FSM is first active at edge SYNC_DEPTH+1.
- HOLD:
  - cnt increments each cycle with hold=0; cnt freezes while hold=1.
  - When cnt==HOLD_CYCLES-1 and hold=0: stage_reset[0]<=0, cnt<=0.
  - If NUM_STAGES==1, go to RUN; otherwise go to RELEASE.
- RELEASE:
  - cnt increments each cycle.
  - When cnt==GAP_CYCLES-1: stage_reset[idx]<=0, cnt<=0, idx<=idx+1.
  - If idx==NUM_STAGES-1, go to RUN.
  - hold is ignored in this state.
- RUN: all_released=1, busy=0.
  - When entering RUN with sw_flag=1: sw_reset_ack pulses for 1 cycle (same cycle all_released rises) and sw_flag clears.
- sw_reset_req sampled high in any state, at the next edge:
  - stage_reset<=all ones, all_released<=0, state<=HOLD, cnt<=0, idx<=1, sw_flag<=1.
  - A held-high request keeps restarting HOLD; the sequence proceeds after the request drops.
- Default timeline (defaults, hold=0):
  - stage_reset[0] falls after edge 18; [1] after edge 26; [2] after edge 34; [3] after edge 42.
  - all_released rises after edge 42.
- reset mid-sequence or in RUN: all outputs return to reset values immediately (async). sw_flag is cleared, so no ack follows.
- stage_reset bits only transition 1->0 in index order, or all->1 together. No other pattern is legal; the bench asserts this.
- Counter width: $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1). idx width: $clog2(NUM_STAGES)+1. No wrap occurs, because cnt is cleared at terminal count.
- Elaboration-time check fails if any parameter is below its stated minimum.

Decomposition:
- Package reset_seq_pkg:
  - state enum typedef (ST_HOLD, ST_RELEASE, ST_RUN)
  - function for counter width from HOLD/GAP
- Sub-module reset_sync (param SYNC_DEPTH; ports clk, reset, rst_sync): async-assert, sync-deassert chain. Instanced once.

Test Plan:
- Defaults; reset high 5 cycles, then low -> stage_reset 4'b1111 until edge 18, then 1110, 1100 @26, 1000 @34, 0000 @42; all_released=1 and busy=0 after edge 42; sw_reset_ack stays 0.
- hold=1 from power-up until edge 30, then 0 -> stage 0 released 15 active cycles later (after edge 45), remaining stages at +8/+16/+24 edges.
- In RUN, 1-cycle sw_reset_req -> next edge stage_reset=1111, busy=1; stages re-release at +16/+24/+32/+40 edges; sw_reset_ack pulses once with all_released rise.
- sw_reset_req while stage 2 is pending -> all stages re-asserted next edge, HOLD restarts from cnt=0, and a single ack at the end.
- reset pulsed asynchronously between clock edges mid-RELEASE -> stage_reset=1111 without a clock edge; full sequence restarts; no sw_reset_ack.
- NUM_STAGES=1, HOLD_CYCLES=1, GAP_CYCLES=1, SYNC_DEPTH=3 -> stage_reset falls after edge 4; all_released=1 the same edge.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_e;

    // Counter must reach the larger of the two terminal counts.
    function automatic int unsigned cnt_width(input int unsigned hold_cycles,
                                              input int unsigned gap_cycles);
        int unsigned max_c;
        max_c = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
        return $clog2(max_c + 1);
    endfunction

endpackage

// File: rtl/reset_sync.sv
// Reset synchronizer: asserts asynchronously, releases SYNC_DEPTH clk edges after reset falls.
module reset_sync #(
    parameter int unsigned SYNC_DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    output logic rst_sync
);

    logic [SYNC_DEPTH-1:0] r_chain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_chain <= '1;
        end else begin
            r_chain <= {r_chain[SYNC_DEPTH-2:0], 1'b0};
        end
    end

    assign rst_sync = r_chain[SYNC_DEPTH-1];

endmodule

// File: rtl/reset_sequencer.sv
// Sequenced reset controller: synchronized release, hold interval, then per-stage release
// with a fixed gap; a software request re-runs the whole sequence.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned NUM_STAGES  = 4,
    parameter int unsigned SYNC_DEPTH  = 2,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned GAP_CYCLES  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sw_reset_req,
    input  logic                  hold,
    output logic [NUM_STAGES-1:0] stage_reset,
    output logic                  all_released,
    output logic                  busy,
    output logic                  sw_reset_ack
);

    localparam int unsigned CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES);
    localparam int unsigned IDX_W = $clog2(NUM_STAGES) + 1;

    localparam logic [CNT_W-1:0]      HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]      GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_STAGES - 1);
    localparam logic [NUM_STAGES-1:0] STAGE_ONE = NUM_STAGES'(1);

    if (NUM_STAGES < 1) begin : g_chk_stages
        $error("reset_sequencer: NUM_STAGES must be >= 1");
    end
    if (SYNC_DEPTH < 2) begin : g_chk_sync
        $error("reset_sequencer: SYNC_DEPTH must be >= 2");
    end
    if (HOLD_CYCLES < 1) begin : g_chk_hold
        $error("reset_sequencer: HOLD_CYCLES must be >= 1");
    end
    if (GAP_CYCLES < 1) begin : g_chk_gap
        $error("reset_sequencer: GAP_CYCLES must be >= 1");
    end

    logic                  w_rst_sync;
    state_e                r_state,        w_state_next;
    logic [CNT_W-1:0]      r_cnt,          w_cnt_next;
    logic [IDX_W-1:0]      r_idx,          w_idx_next;
    logic                  r_sw_flag,      w_sw_flag_next;
    logic [NUM_STAGES-1:0] r_stage_reset,  w_stage_reset_next;
    logic                  r_all_released, w_all_released_next;
    logic                  r_busy,         w_busy_next;
    logic                  r_sw_reset_ack, w_sw_reset_ack_next;

    reset_sync #(
        .SYNC_DEPTH (SYNC_DEPTH)
    ) u_reset_sync (
        .clk      (clk),
        .reset    (reset),
        .rst_sync (w_rst_sync)
    );

    always_ff @(posedge clk or posedge w_rst_sync) begin
        if (w_rst_sync) begin
            r_state        <= ST_HOLD;
            r_cnt          <= '0;
            r_idx          <= IDX_W'(1);
            r_sw_flag      <= 1'b0;
            r_stage_reset  <= '1;
            r_all_released <= 1'b0;
            r_busy         <= 1'b1;
            r_sw_reset_ack <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_cnt          <= w_cnt_next;
            r_idx          <= w_idx_next;
            r_sw_flag      <= w_sw_flag_next;
            r_stage_reset  <= w_stage_reset_next;
            r_all_released <= w_all_released_next;
            r_busy         <= w_busy_next;
            r_sw_reset_ack <= w_sw_reset_ack_next;
        end
    end

    always_comb begin
        w_state_next        = r_state;
        w_cnt_next          = r_cnt;
        w_idx_next          = r_idx;
        w_sw_flag_next      = r_sw_flag;
        w_stage_reset_next  = r_stage_reset;
        w_all_released_next = r_all_released;
        w_busy_next         = r_busy;
        w_sw_reset_ack_next = 1'b0;

        // Software request overrides every state and restarts from the top.
        if (sw_reset_req) begin
            w_state_next        = ST_HOLD;
            w_cnt_next          = '0;
            w_idx_next          = IDX_W'(1);
            w_sw_flag_next      = 1'b1;
            w_stage_reset_next  = '1;
            w_all_released_next = 1'b0;
            w_busy_next         = 1'b1;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (!hold) begin
                        if (r_cnt == HOLD_LAST) begin
                            w_stage_reset_next = r_stage_reset & ~STAGE_ONE;
                            w_cnt_next         = '0;
                            if (NUM_STAGES == 1) begin
                                w_state_next        = ST_RUN;
                                w_all_released_next = 1'b1;
                                w_busy_next         = 1'b0;
                                w_sw_reset_ack_next = r_sw_flag;
                                w_sw_flag_next      = 1'b0;
                            end else begin
                                w_state_next = ST_RELEASE;
                            end
                        end else begin
                            w_cnt_next = r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_RELEASE: begin
                    if (r_cnt == GAP_LAST) begin
                        w_stage_reset_next = r_stage_reset & ~(STAGE_ONE << r_idx);
                        w_cnt_next         = '0;
                        w_idx_next         = r_idx + IDX_W'(1);
                        if (r_idx == IDX_LAST) begin
                            w_state_next        = ST_RUN;
                            w_all_released_next = 1'b1;
                            w_busy_next         = 1'b0;
                            w_sw_reset_ack_next = r_sw_flag;
                            w_sw_flag_next      = 1'b0;
                        end
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                end
                default: begin
                    w_state_next = ST_HOLD;
                end
            endcase
        end
    end

    assign stage_reset  = r_stage_reset;
    assign all_released = r_all_released;
    assign busy         = r_busy;
    assign sw_reset_ack = r_sw_reset_ack;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: expected output changes are queued with their edge number and a
// negedge monitor matches every observed output change against the queue.
module tb_reset_sequencer;

    localparam int unsigned NS = 4;

    logic          clk          = 1'b0;
    logic          reset        = 1'b1;
    logic          sw_reset_req = 1'b0;
    logic          hold         = 1'b0;
    logic [NS-1:0] stage_reset;
    logic          all_released;
    logic          busy;
    logic          sw_reset_ack;

    logic          reset2 = 1'b1;
    logic          req2   = 1'b0;
    logic          hold2  = 1'b0;
    logic [0:0]    stage_reset2;
    logic          all_released2;
    logic          busy2;
    logic          sw_reset_ack2;

    reset_sequencer #(
        .NUM_STAGES (NS),
        .SYNC_DEPTH (2),
        .HOLD_CYCLES(16),
        .GAP_CYCLES (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sw_reset_req(sw_reset_req),
        .hold        (hold),
        .stage_reset (stage_reset),
        .all_released(all_released),
        .busy        (busy),
        .sw_reset_ack(sw_reset_ack)
    );

    reset_sequencer #(
        .NUM_STAGES (1),
        .SYNC_DEPTH (3),
        .HOLD_CYCLES(1),
        .GAP_CYCLES (1)
    ) dut_min (
        .clk         (clk),
        .reset       (reset2),
        .sw_reset_req(req2),
        .hold        (hold2),
        .stage_reset (stage_reset2),
        .all_released(all_released2),
        .busy        (busy2),
        .sw_reset_ack(sw_reset_ack2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NS-1:0] stage;
        logic          ar;
        logic          bsy;
        logic          ack;
        int            at;
    } ev_t;

    ev_t           q[$];
    int            errors = 0;
    int            checks = 0;
    bit            mon_en = 1'b0;
    logic [NS-1:0] p_stage;
    logic          p_ar, p_bsy, p_ack;

    task automatic push(input int at, input logic [NS-1:0] st, input logic ar,
                        input logic bsy, input logic ack);
        ev_t e;
        e.stage = st; e.ar = ar; e.bsy = bsy; e.ack = ack; e.at = at;
        q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Every output change must match the next queued event, including the edge it occurs on.
    always @(negedge clk) begin
        ev_t e;
        if (mon_en) begin
            if (q.size() > 0 && q[0].at < cyc) begin
                e = q.pop_front();
                checks++; errors++;
                $display("FAIL missed_event: expected stage=%b ar=%b busy=%b ack=%b at edge %0d, none by edge %0d",
                         e.stage, e.ar, e.bsy, e.ack, e.at, cyc);
            end
            if ({stage_reset, all_released, busy, sw_reset_ack} !== {p_stage, p_ar, p_bsy, p_ack}) begin
                checks++;
                if (!(stage_reset == '1 || stage_reset == p_stage || stage_reset == (p_stage << 1))) begin
                    errors++;
                    $display("FAIL stage_order: got %b after %b", stage_reset, p_stage);
                end
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: got stage=%b ar=%b busy=%b ack=%b at edge %0d",
                             stage_reset, all_released, busy, sw_reset_ack, cyc);
                end else begin
                    e = q.pop_front();
                    if (e.stage !== stage_reset || e.ar !== all_released || e.bsy !== busy ||
                        e.ack !== sw_reset_ack || e.at != cyc) begin
                        errors++;
                        $display("FAIL event: got stage=%b ar=%b busy=%b ack=%b at edge %0d, expected stage=%b ar=%b busy=%b ack=%b at edge %0d",
                                 stage_reset, all_released, busy, sw_reset_ack, cyc,
                                 e.stage, e.ar, e.bsy, e.ack, e.at);
                    end
                end
                p_stage = stage_reset; p_ar = all_released; p_bsy = busy; p_ack = sw_reset_ack;
            end
        end
    end

    initial begin
        int base;
        int e0;
        int e1;

        // Reset values while reset is held
        step(5);
        check("rst_stage", 32'(stage_reset), 32'hF);
        check("rst_all_released", 32'(all_released), 32'h0);
        check("rst_busy", 32'(busy), 32'h1);
        check("rst_ack", 32'(sw_reset_ack), 32'h0);
        check("rst2_stage", 32'(stage_reset2), 32'h1);
        check("rst2_busy", 32'(busy2), 32'h1);
        p_stage = 4'b1111; p_ar = 1'b0; p_bsy = 1'b1; p_ack = 1'b0;
        mon_en = 1'b1;

        // Default power-up sequence
        reset = 1'b0;
        base  = cyc;
        push(base + 18, 4'b1110, 1'b0, 1'b1, 1'b0);
        push(base + 26, 4'b1100, 1'b0, 1'b1, 1'b0);
        push(base + 34, 4'b1000, 1'b0, 1'b1, 1'b0);
        push(base + 42, 4'b0000, 1'b1, 1'b0, 1'b0);
        step(47);

        // hold high from power-up until edge 30
        hold = 1'b1;
        push(cyc, 4'b1111, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        base  = cyc;
        push(base + 45, 4'b1110, 1'b0, 1'b1, 1'b0);
        push(base + 53, 4'b1100, 1'b0, 1'b1, 1'b0);
        push(base + 61, 4'b1000, 1'b0, 1'b1, 1'b0);
        push(base + 69, 4'b0000, 1'b1, 1'b0, 1'b0);
        step(29);
        hold = 1'b0;
        step(45);

        // One-cycle software request from RUN
        sw_reset_req = 1'b1;
        e0 = cyc + 1;
        push(e0,      4'b1111, 1'b0, 1'b1, 1'b0);
        push(e0 + 16, 4'b1110, 1'b0, 1'b1, 1'b0);
        push(e0 + 24, 4'b1100, 1'b0, 1'b1, 1'b0);
        push(e0 + 32, 4'b1000, 1'b0, 1'b1, 1'b0);
        push(e0 + 40, 4'b0000, 1'b1, 1'b0, 1'b1);
        push(e0 + 41, 4'b0000, 1'b1, 1'b0, 1'b0);
        step(1);
        sw_reset_req = 1'b0;
        step(45);

        // Request again while stage 2 is pending, held for three edges
        sw_reset_req = 1'b1;
        e0 = cyc + 1;
        push(e0,      4'b1111, 1'b0, 1'b1, 1'b0);
        push(e0 + 16, 4'b1110, 1'b0, 1'b1, 1'b0);
        push(e0 + 24, 4'b1100, 1'b0, 1'b1, 1'b0);
        step(1);
        sw_reset_req = 1'b0;
        step(27);
        sw_reset_req = 1'b1;
        e1 = cyc + 1;
        push(e1,      4'b1111, 1'b0, 1'b1, 1'b0);
        push(e1 + 18, 4'b1110, 1'b0, 1'b1, 1'b0);
        push(e1 + 26, 4'b1100, 1'b0, 1'b1, 1'b0);
        push(e1 + 34, 4'b1000, 1'b0, 1'b1, 1'b0);
        push(e1 + 42, 4'b0000, 1'b1, 1'b0, 1'b1);
        push(e1 + 43, 4'b0000, 1'b1, 1'b0, 1'b0);
        step(3);
        sw_reset_req = 1'b0;
        step(45);

        // Async reset pulse mid-RELEASE during a software sequence: no ack afterwards
        sw_reset_req = 1'b1;
        e0 = cyc + 1;
        push(e0,      4'b1111, 1'b0, 1'b1, 1'b0);
        push(e0 + 16, 4'b1110, 1'b0, 1'b1, 1'b0);
        push(e0 + 24, 4'b1100, 1'b0, 1'b1, 1'b0);
        step(1);
        sw_reset_req = 1'b0;
        step(27);
        #2;
        push(cyc, 4'b1111, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        #1;
        check("async_stage", 32'(stage_reset), 32'hF);
        check("async_busy", 32'(busy), 32'h1);
        check("async_all_released", 32'(all_released), 32'h0);
        reset = 1'b0;
        base  = cyc;
        push(base + 18, 4'b1110, 1'b0, 1'b1, 1'b0);
        push(base + 26, 4'b1100, 1'b0, 1'b1, 1'b0);
        push(base + 34, 4'b1000, 1'b0, 1'b1, 1'b0);
        push(base + 42, 4'b0000, 1'b1, 1'b0, 1'b0);
        step(47);

        // Minimal configuration: single stage released at edge 4
        reset2 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step(1);
            check($sformatf("min_stage_e%0d", k), 32'(stage_reset2), (k < 4) ? 32'h1 : 32'h0);
            check($sformatf("min_all_released_e%0d", k), 32'(all_released2), (k < 4) ? 32'h0 : 32'h1);
            check($sformatf("min_busy_e%0d", k), 32'(busy2), (k < 4) ? 32'h1 : 32'h0);
            check($sformatf("min_ack_e%0d", k), 32'(sw_reset_ack2), 32'h0);
        end

        step(2);
        check("pending_events", 32'(q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
